gps_ca_acq: RTL and testbench
=============================

# gps_ca_acq

Serial C/A-code acquisition engine: the receive-side counterpart of the GPS signal generator. It consumes a 1-bit, one-sample-per-chip baseband stream and correlates it against a locally generated GPS L1 C/A Gold code for a selected PRN. It slides its local code phase one chip per code epoch until the correlation magnitude reaches a threshold, then reports lock, code phase and per-epoch correlation. It sits after the sample slicer in the receive path and feeds status to the top-level outputs.

## Interface
Parameters:
- EPOCH_LEN, 1023, chips per correlation epoch (one C/A period).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; loads config and (re)starts search from any state.
- tap_a  in  4  first G2 phase-select tap (1..10).
- tap_b  in  4  second G2 phase-select tap (1..10).
- thr  in  10  lock threshold on correlation magnitude.
- din  in  1  received chip (1 means +1, 0 means -1).
- din_valid  in  1  qualifies din; one chip per asserted cycle.
- locked  out  1  high while in LOCKED.
- code_phase  out  10  local code delay in chips applied so far, 0..1022.
- corr_mag  out  10  |accumulator| of the last completed epoch.
- epoch_done  out  1  one-cycle pulse when corr_mag updates.
- search_fail  out  1  one-cycle pulse after EPOCH_LEN phases are tried without lock.
- cfg_err  out  1  one-cycle pulse when start carries invalid taps.

## Operation
- Code generator: G1 = 1+x^3+x^10 and G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10. Both are 10-bit registers and both are loaded all-ones on start. The local chip is G1[10] XOR G2[tap_a] XOR G2[tap_b]. Both LFSRs advance once per accepted din_valid.
- Taps are latched on start. The taps are invalid if either is 0 or greater than 10, or if tap_a equals tap_b. An invalid start pulses cfg_err and forces IDLE.
- Correlation: each accepted chip adds +1 to an 11-bit signed accumulator when din XNOR local is 1, and adds -1 otherwise. A chip counter ends the epoch after EPOCH_LEN accepted chips. At epoch end: corr_mag = |acc|, which fits 10 bits with no saturation. The accumulator and chip counter then clear.
- States:
  - IDLE: no accumulation; all outputs are held.
  - SEARCH: at each epoch end, if corr_mag >= thr, go to LOCKED. Otherwise perform a slip: the first din_valid of the next epoch is discarded. On that discarded chip the LFSRs do not advance, nothing is accumulated and the chip counter does not count. code_phase then increments, wrapping 1022->0. When the wrap occurs, search_fail pulses and the search continues.
  - LOCKED: no slips. At each epoch end, if corr_mag < thr, return to SEARCH and slip as above.
- Transitions from SEARCH/LOCKED to IDLE happen only via reset or an invalid start. A valid start in any state reloads the LFSRs, clears acc, the chip counter and code_phase, drops locked, and enters SEARCH.
- din_valid gaps are allowed. The internal state simply holds while din_valid is low.
- An inverted stream (data bit = 1) gives acc = -1023 and is still a lock, because the lock decision uses the magnitude.

## Timing
- Reset values: locked=0, code_phase=0, corr_mag=0, epoch_done=0, search_fail=0, cfg_err=0. State is IDLE and both LFSRs are all-ones.
- epoch_done, corr_mag, locked and code_phase all update on the clock edge after the cycle carrying the EPOCH_LEN-th accepted chip. All are registered with 1-cycle latency.
- search_fail and cfg_err are each a single-cycle pulse, issued on that same update edge (cfg_err: on the edge after start).
- If start and din_valid occur in the same cycle, start wins and that chip is not accumulated.
- A slip is pending from the epoch_done edge until the next din_valid. A start while a slip is pending cancels the slip.
- Asserting rst_n low mid-epoch clears everything immediately. The first epoch after reset is only counted after a start.

## Test plan
- Taps 2,6 (PRN1); drive the exact PRN1 code with din_valid=1 on every cycle, then start -> epoch_done at cycle 1024 after start with corr_mag=1023, locked=1, code_phase=0.
- PRN1 input delayed by 5 chips, thr=800 -> corr_mag of 65 or less on epochs 1-5; locked=1 after epoch 6 with code_phase=5; corr_mag=1023.
- PRN1 input with every chip inverted and random din_valid gaps (50%) -> locked=1 after the first epoch, corr_mag=1023, timing stretched but result unchanged.
- PRN2 code (taps 3,7) into a PRN1 search, thr=500 -> never locked; search_fail pulses once after 1023 epochs; code_phase returns to 0.
- Locked on PRN1, then din held at 0 -> next corr_mag=1, locked drops, code_phase becomes 1 after the following epoch. Separately, start with tap_a=tap_b=4 -> cfg_err pulse, state IDLE, no epoch_done.
- rst_n pulsed low at chip 500 of epoch 3 of a search -> all outputs return to reset values immediately; a new start relocks PRN1 with zero offset after one epoch.

Source files
------------

// File: rtl/gps_ca_acq.sv
`default_nettype none
// ============================================================================
// Module   : gps_ca_acq
// Brief    : Serial GPS L1 C/A code acquisition (one-chip slip per epoch).
// Revision : 1.0 - initial release
// ============================================================================
module gps_ca_acq #(
    parameter int EPOCH_LEN = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] tap_a,
    input  logic [3:0] tap_b,
    input  logic [9:0] thr,
    input  logic       din,
    input  logic       din_valid,
    output logic       locked,
    output logic [9:0] code_phase,
    output logic [9:0] corr_mag,
    output logic       epoch_done,
    output logic       search_fail,
    output logic       cfg_err
);

    localparam logic [9:0] c_last_idx = 10'(EPOCH_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [10:1]        g1_q, g1_d, g2_q, g2_d;
    logic [3:0]         tap_a_q, tap_a_d, tap_b_q, tap_b_d;
    logic [9:0]         thr_q, thr_d;
    logic signed [10:0] acc_q, acc_d;
    logic [9:0]         cnt_q, cnt_d;
    logic               slip_q, slip_d;
    logic               locked_q, locked_d;
    logic [9:0]         code_phase_q, code_phase_d;
    logic [9:0]         corr_mag_q, corr_mag_d;
    logic               epoch_done_q, epoch_done_d;
    logic               search_fail_q, search_fail_d;
    logic               cfg_err_q, cfg_err_d;

    logic               w_taps_ok;
    logic [15:0]        w_g2_ext;
    logic               w_local;
    logic signed [10:0] w_acc_sum;
    logic [9:0]         w_mag;

    assign w_taps_ok = (tap_a != 4'd0) && (tap_a <= 4'd10) &&
                       (tap_b != 4'd0) && (tap_b <= 4'd10) && (tap_a != tap_b);

    // G2 stages sit at bit positions 1..10 so the tap value indexes directly.
    assign w_g2_ext  = {5'b0, g2_q, 1'b0};
    assign w_local   = g1_q[10] ^ w_g2_ext[tap_a_q] ^ w_g2_ext[tap_b_q];
    assign w_acc_sum = acc_q + ((din ~^ w_local) ? 11'sd1 : -11'sd1);
    assign w_mag     = w_acc_sum[10] ? 10'(-w_acc_sum) : w_acc_sum[9:0];

    always_comb begin
        state_d       = state_q;
        g1_d          = g1_q;
        g2_d          = g2_q;
        tap_a_d       = tap_a_q;
        tap_b_d       = tap_b_q;
        thr_d         = thr_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        slip_d        = slip_q;
        locked_d      = locked_q;
        code_phase_d  = code_phase_q;
        corr_mag_d    = corr_mag_q;
        epoch_done_d  = 1'b0;
        search_fail_d = 1'b0;
        cfg_err_d     = 1'b0;

        if (start) begin
            slip_d   = 1'b0;
            locked_d = 1'b0;
            if (w_taps_ok) begin
                tap_a_d      = tap_a;
                tap_b_d      = tap_b;
                thr_d        = thr;
                g1_d         = '1;
                g2_d         = '1;
                acc_d        = '0;
                cnt_d        = '0;
                code_phase_d = '0;
                state_d      = S_SEARCH;
            end else begin
                cfg_err_d = 1'b1;
                state_d   = S_IDLE;
            end
        end else if (din_valid && (state_q != S_IDLE)) begin
            if (slip_q) begin
                // Discarded chip: the local code falls one chip behind the input.
                slip_d = 1'b0;
            end else begin
                g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
                g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
                if (cnt_q == c_last_idx) begin
                    acc_d        = '0;
                    cnt_d        = '0;
                    corr_mag_d   = w_mag;
                    epoch_done_d = 1'b1;
                    if (w_mag >= thr_q) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d  = S_SEARCH;
                        locked_d = 1'b0;
                        slip_d   = 1'b1;
                        if (code_phase_q == c_last_idx) begin
                            code_phase_d  = '0;
                            search_fail_d = 1'b1;
                        end else begin
                            code_phase_d = code_phase_q + 10'd1;
                        end
                    end
                end else begin
                    acc_d = w_acc_sum;
                    cnt_d = cnt_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            g1_q          <= '1;
            g2_q          <= '1;
            tap_a_q       <= '0;
            tap_b_q       <= '0;
            thr_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            slip_q        <= 1'b0;
            locked_q      <= 1'b0;
            code_phase_q  <= '0;
            corr_mag_q    <= '0;
            epoch_done_q  <= 1'b0;
            search_fail_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            g1_q          <= g1_d;
            g2_q          <= g2_d;
            tap_a_q       <= tap_a_d;
            tap_b_q       <= tap_b_d;
            thr_q         <= thr_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            slip_q        <= slip_d;
            locked_q      <= locked_d;
            code_phase_q  <= code_phase_d;
            corr_mag_q    <= corr_mag_d;
            epoch_done_q  <= epoch_done_d;
            search_fail_q <= search_fail_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign locked      = locked_q;
    assign code_phase  = code_phase_q;
    assign corr_mag    = corr_mag_q;
    assign epoch_done  = epoch_done_q;
    assign search_fail = search_fail_q;
    assign cfg_err     = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_ca_acq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gps_ca_acq
// Brief    : Directed, table-driven self-checking bench for gps_ca_acq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gps_ca_acq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tap_a = '0;
    logic [3:0] tap_b = '0;
    logic [9:0] thr = '0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       locked, epoch_done, search_fail, cfg_err;
    logic [9:0] code_phase, corr_mag;
    logic       s_locked, s_epoch_done, s_search_fail, s_cfg_err;
    logic [9:0] s_code_phase, s_corr_mag;

    int n_checks = 0;
    int n_fail   = 0;
    int kk       = 0;
    int dly      = 0;
    bit code_m [0:1022];

    typedef struct {
        int ta; int tb; int thr; int sa; int sb; int delay; int inv; int gaps;
        int n_ep; int first_done; int chk_mag; int exp_mag; int early_max;
        int exp_lock; int exp_phase;
    } vec_t;
    vec_t vt [8];

    gps_ca_acq #(.EPOCH_LEN(1023)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tap_a(tap_a), .tap_b(tap_b),
        .thr(thr), .din(din), .din_valid(din_valid), .locked(locked),
        .code_phase(code_phase), .corr_mag(corr_mag), .epoch_done(epoch_done),
        .search_fail(search_fail), .cfg_err(cfg_err)
    );

    // Short-epoch instance so a full phase sweep fits in a few hundred cycles.
    gps_ca_acq #(.EPOCH_LEN(8)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .tap_a(tap_a), .tap_b(tap_b),
        .thr(thr), .din(din), .din_valid(din_valid), .locked(s_locked),
        .code_phase(s_code_phase), .corr_mag(s_corr_mag), .epoch_done(s_epoch_done),
        .search_fail(s_search_fail), .cfg_err(s_cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        n_checks++;
        if (act > lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for epoch_done", name);
    endtask

    task automatic gen_code(input int ta, input int tb);
        bit [10:1] g1;
        bit [10:1] g2;
        bit        f1;
        bit        f2;
        g1 = '1;
        g2 = '1;
        for (int i = 0; i < 1023; i++) begin
            code_m[i] = g1[10] ^ g2[ta] ^ g2[tb];
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            g1 = {g1[9:1], f1};
            g2 = {g2[9:1], f2};
        end
    endtask

    task automatic do_start(input int ta, input int tb, input int th);
        @(negedge clk);
        tap_a = 4'(ta);
        tap_b = 4'(tb);
        thr = 10'(th);
        start = 1'b1;
        din_valid = 1'b0;
        kk = 0;
    endtask

    // mode 0: code_m delayed by dly; 1: constant 0; other: random
    task automatic tick(input int mode);
        @(negedge clk);
        start = 1'b0;
        din_valid = 1'b1;
        case (mode)
            0: begin
                din = code_m[(kk + 1023 - dly) % 1023];
                kk++;
            end
            1: din = 1'b0;
            default: din = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_done(input int n, input int mode, input int limit, input string name);
        int seen;
        int c;
        seen = 0;
        c = 0;
        while (seen < n && c < limit) begin
            tick(mode);
            c++;
            if (epoch_done) seen++;
        end
        if (seen < n) timeout(name);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        int cyc;
        int ne;
        int pos;
        gen_code(v.sa, v.sb);
        @(negedge clk);
        tap_a = 4'(v.ta);
        tap_b = 4'(v.tb);
        thr = 10'(v.thr);
        start = 1'b1;
        din_valid = 1'b1;
        pos = (1023 - v.delay) % 1023;
        din = ~(code_m[pos] ^ v.inv[0]);
        k = 0;
        cyc = 0;
        ne = 0;
        while (ne < v.n_ep && cyc < 3000 * v.n_ep) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (epoch_done) begin
                ne++;
                if (ne == 1 && v.first_done != 0)
                    chk($sformatf("v%0d_first_done_cycle", idx), cyc, v.first_done);
                if (ne < v.n_ep) begin
                    chk_le($sformatf("v%0d_early_mag_ep%0d", idx, ne), int'(corr_mag), v.early_max);
                    chk($sformatf("v%0d_early_unlocked_ep%0d", idx, ne), int'(locked), 0);
                end
            end
            if (ne < v.n_ep) begin
                din_valid = (v.gaps != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (din_valid) begin
                    pos = (k + 1023 * 4 - v.delay) % 1023;
                    din = code_m[pos] ^ v.inv[0];
                    k++;
                end
            end else begin
                din_valid = 1'b0;
            end
        end
        if (ne < v.n_ep) timeout($sformatf("v%0d_epochs", idx));
        if (v.chk_mag != 0) chk($sformatf("v%0d_corr_mag", idx), int'(corr_mag), v.exp_mag);
        else chk_le($sformatf("v%0d_corr_mag", idx), int'(corr_mag), v.early_max);
        chk($sformatf("v%0d_locked", idx), int'(locked), v.exp_lock);
        chk($sformatf("v%0d_code_phase", idx), int'(code_phase), v.exp_phase);
    endtask

    initial begin
        int cnt;
        int ne;
        int sf_ep;
        bit [9:0] first10;
        int bad_taps [4][2];

        //            ta tb  thr  sa sb dly inv gap n  1st  cm  mag  early lk ph
        vt[0] = '{2, 6, 1023, 2, 6, 0, 0, 0, 1, 1024, 1, 1023, 0, 1, 0};
        vt[1] = '{2, 6, 800,  2, 6, 5, 0, 0, 6, 0,    1, 1023, 65, 1, 5};
        vt[2] = '{2, 6, 1000, 2, 6, 0, 1, 1, 1, 0,    1, 1023, 0, 1, 0};
        vt[3] = '{2, 6, 500,  3, 7, 0, 0, 0, 10, 0,   0, 0,    65, 0, 10};
        vt[4] = '{3, 7, 900,  3, 7, 2, 0, 0, 3, 0,    1, 1023, 65, 1, 2};
        vt[5] = '{1, 10, 1023, 1, 10, 0, 0, 0, 1, 0,  1, 1023, 0, 1, 0};
        vt[6] = '{2, 6, 1,    2, 6, 1, 0, 0, 1, 0,    1, 1,    0, 1, 0};
        vt[7] = '{2, 6, 2,    2, 6, 1, 0, 0, 2, 0,    1, 1023, 1, 1, 1};
        bad_taps = '{'{4, 4}, '{0, 3}, '{11, 2}, '{5, 15}};

        repeat (3) @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_code_phase", int'(code_phase), 0);
        chk("rst_corr_mag", int'(corr_mag), 0);
        chk("rst_epoch_done", int'(epoch_done), 0);
        chk("rst_search_fail", int'(search_fail), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;

        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(2);
            if (epoch_done) cnt++;
        end
        chk("no_epoch_before_start", cnt, 0);

        gen_code(2, 6);
        for (int i = 0; i < 10; i++) first10[9 - i] = code_m[i];
        chk("prn1_first10_octal1440", int'(first10), 'o1440);
        gen_code(3, 7);
        for (int i = 0; i < 10; i++) first10[9 - i] = code_m[i];
        chk("prn2_first10_octal1620", int'(first10), 'o1620);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Lock, then lose it with a constant-zero stream.
        gen_code(2, 6);
        dly = 0;
        do_start(2, 6, 1000);
        wait_done(1, 0, 2000, "lockloss_lock");
        chk("lockloss_locked_first", int'(locked), 1);
        wait_done(1, 1, 2000, "lockloss_drop");
        chk("lockloss_corr_mag", int'(corr_mag), 1);
        chk("lockloss_locked", int'(locked), 0);
        chk("lockloss_code_phase", int'(code_phase), 1);

        // Invalid tap configurations.
        for (int i = 0; i < 4; i++) begin
            do_start(bad_taps[i][0], bad_taps[i][1], 1000);
            tick(2);
            chk($sformatf("cfg_err_pulse_%0d", i), int'(cfg_err), 1);
            chk($sformatf("cfg_err_small_%0d", i), int'(s_cfg_err), 1);
            chk($sformatf("cfg_err_locked_%0d", i), int'(locked), 0);
            tick(2);
            chk($sformatf("cfg_err_single_%0d", i), int'(cfg_err), 0);
        end
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(2);
            if (epoch_done) cnt++;
        end
        chk("cfg_err_idle_no_epoch", cnt, 0);
        chk("cfg_err_phase_held", int'(code_phase), 1);

        // Reset in the middle of the third search epoch.
        gen_code(2, 6);
        dly = 5;
        do_start(2, 6, 800);
        tick(0);
        chk("valid_start_no_cfg_err", int'(cfg_err), 0);
        wait_done(2, 0, 3000, "rst_mid_search");
        chk("rst_mid_phase_before", int'(code_phase), 2);
        repeat (500) tick(0);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_locked", int'(locked), 0);
        chk("rst_mid_code_phase", int'(code_phase), 0);
        chk("rst_mid_corr_mag", int'(corr_mag), 0);
        chk("rst_mid_epoch_done", int'(epoch_done), 0);
        chk("rst_mid_search_fail", int'(search_fail), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(2);
            if (epoch_done) cnt++;
        end
        chk("rst_mid_idle_no_epoch", cnt, 0);
        dly = 0;
        do_start(2, 6, 1000);
        wait_done(1, 0, 2000, "rst_relock");
        chk("rst_relock_corr_mag", int'(corr_mag), 1023);
        chk("rst_relock_locked", int'(locked), 1);
        chk("rst_relock_code_phase", int'(code_phase), 0);

        // Full phase sweep on the 8-chip instance: search_fail on the 8th epoch.
        do_start(2, 6, 1023);
        ne = 0;
        sf_ep = 0;
        for (int c = 0; c < 200 && sf_ep == 0; c++) begin
            tick(2);
            if (s_epoch_done) ne++;
            if (s_search_fail) sf_ep = ne;
            else if (s_epoch_done) begin
                chk($sformatf("sweep_phase_ep%0d", ne), int'(s_code_phase), ne);
                chk_le($sformatf("sweep_mag_ep%0d", ne), int'(s_corr_mag), 8);
            end
        end
        chk("sweep_fail_epoch", sf_ep, 8);
        chk("sweep_fail_phase_wrap", int'(s_code_phase), 0);
        chk("sweep_never_locked", int'(s_locked), 0);
        tick(2);
        chk("sweep_fail_single_pulse", int'(s_search_fail), 0);

        din_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
